sample_batch_ctrl: RTL

Controller that sequences one batch of input samples into the sample-processing datapath. It arms on a start pulse and paces an upstream valid/ready sample stream, inserting a fixed processing gap after each accepted sample. It counts accepted samples to a programmable batch length, flags completion until acknowledged, and traps protocol overruns and, optionally, stalls. It sits between the sample source and the datapath, and gives the top-level control FSM a single done/error view of each batch.

---
 rtl/sample_batch_ctrl_pkg.sv | 10 +
 rtl/sample_batch_ctrl_if.sv | 26 ++
 rtl/sample_batch_ctrl_batch_counter.sv | 26 ++
 rtl/sample_batch_ctrl.sv | 106 ++++++++++
 4 files changed

// File: rtl/sample_batch_ctrl_pkg.sv
// sample_batch_pkg: shared FSM state type, error-flag bit positions and counter width helper for sample_batch_ctrl
package sample_batch_pkg;
    typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_t;
    localparam int ERR_OVERRUN = 0;
    localparam int ERR_TIMEOUT = 1;
    localparam int ERR_W = 2;
    function automatic int cnt_w(input int n);
        return n < 1 ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/sample_batch_ctrl_if.sv
// sample_batch_ctrl_if: batch control and sample handshake bundle
//   master (controller): in start, sample_valid, done_ack; out sample_ready, sample_accept,
//                        sample_count, busy, batch_done, overrun_err, timeout_err
//   slave  (environment): the mirror image
interface sample_batch_ctrl_if #(parameter int BATCH_LEN = 1000);
    import sample_batch_pkg::*;
    localparam int CNT_W = cnt_w(BATCH_LEN);
    logic             start;
    logic             sample_valid;
    logic             sample_ready;
    logic             sample_accept;
    logic [CNT_W-1:0] sample_count;
    logic             busy;
    logic             batch_done;
    logic             done_ack;
    logic             overrun_err;
    logic             timeout_err;
    modport master (
        input  start, sample_valid, done_ack,
        output sample_ready, sample_accept, sample_count, busy, batch_done, overrun_err, timeout_err
    );
    modport slave (
        output start, sample_valid, done_ack,
        input  sample_ready, sample_accept, sample_count, busy, batch_done, overrun_err, timeout_err
    );
endinterface

// File: rtl/sample_batch_ctrl_batch_counter.sv
// batch_counter: up-counter with sync clear, enable and terminal-value flag
//   clk, rst : clock and synchronous active-high reset
//   clr_i    : clear to 0 (wins over en_i)
//   en_i     : count up by one
//   cnt_o    : current count
//   term_o   : cnt_o equals TERM
module batch_counter #(
    parameter int W    = 8,
    parameter int TERM = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign cnt_o  = cnt_q;
    assign term_o = cnt_q == W'(TERM);
endmodule

// File: rtl/sample_batch_ctrl.sv
// sample_batch_ctrl: paces one batch of upstream samples into the datapath with a post-accept gap,
// flags batch completion until acknowledged and traps overruns (and stalls when
// SAMPLE_BATCH_CTRL_TIMEOUT_EN is defined).
//   clk, rst : clock and synchronous active-high reset
//   bus      : sample_batch_ctrl_if.master (start, sample_valid/ready/accept, sample_count,
//              busy, batch_done, done_ack, overrun_err, timeout_err)
module sample_batch_ctrl
    import sample_batch_pkg::*;
#(
    parameter int BATCH_LEN = 1000,
    parameter int PROC_LAT  = 2,
    parameter int TIMEOUT   = 4096
) (
    input logic                 clk,
    input logic                 rst,
    sample_batch_ctrl_if.master bus
);
    localparam int CNT_W = cnt_w(BATCH_LEN);
    localparam int GAP_W = cnt_w(PROC_LAT);
    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   count;
    logic               accept, arm, last, stall;
    assign accept = bus.sample_valid & ready_q;
    assign arm    = bus.start & (state_q == IDLE || state_q == ERROR);
    // last is high while one accept short of a full batch, so the final accept moves to DONE
    batch_counter #(.W(CNT_W), .TERM(BATCH_LEN - 1)) u_sample_cnt (
        .clk(clk), .rst(rst), .clr_i(arm), .en_i(accept), .cnt_o(count), .term_o(last)
    );
`ifdef SAMPLE_BATCH_CTRL_TIMEOUT_EN
    localparam int IDLE_W = cnt_w(TIMEOUT);
    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_term;
    // Every non-accepting COLLECT cycle is idle; the TIMEOUT-th one trips the stall.
    batch_counter #(.W(IDLE_W), .TERM(TIMEOUT - 1)) u_idle_cnt (
        .clk(clk), .rst(rst), .clr_i(arm | accept), .en_i(state_q == COLLECT),
        .cnt_o(idle_cnt), .term_o(idle_term)
    );
    assign stall = state_q == COLLECT && !accept && idle_term && idle_cnt != '0 || (state_q == COLLECT && !accept && idle_term && TIMEOUT == 1);
`else
    assign stall = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    gap_d   = '0;
                end
            end
            COLLECT: begin
                gap_d = accept ? GAP_W'(PROC_LAT) : gap_q != '0 ? gap_q - 1'b1 : gap_q;
                if (bus.sample_valid && !ready_q) begin
                    state_d            = ERROR;
                    err_d[ERR_OVERRUN] = 1'b1;
                end else if (accept && last) begin
                    state_d = DONE;
                end else if (stall) begin
                    state_d            = ERROR;
                    err_d[ERR_TIMEOUT] = 1'b1;
                end
            end
            DONE: begin
                if (bus.done_ack) state_d = IDLE;
            end
            default: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    gap_d   = '0;
                    err_d   = '0;
                end
            end
        endcase
        // Ready only from the second COLLECT cycle on, and never on the way out of COLLECT
        ready_d = state_q == COLLECT && state_d == COLLECT && gap_d == '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            gap_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
        end
    end
    assign bus.sample_ready  = ready_q;
    assign bus.sample_accept = accept;
    assign bus.sample_count  = count;
    assign bus.busy          = state_q == COLLECT;
    assign bus.batch_done    = state_q == DONE;
    assign bus.overrun_err   = err_q[ERR_OVERRUN];
`ifdef SAMPLE_BATCH_CTRL_TIMEOUT_EN
    assign bus.timeout_err   = err_q[ERR_TIMEOUT];
`else
    assign bus.timeout_err   = 1'b0;
`endif
endmodule
